sumador_rr_arb: RTL and testbench
=================================

# sumador_rr_arb

Round-robin arbiter sharing one `sumadorb` adder instance among `R` requesters. Each requester presents an N-bit operand pair with a valid/ready handshake. The arbiter grants one requester per cycle, registers the sum, and returns it with the winner's ID on a single result channel with backpressure. It sits between the requesting datapath units and the shared adder resource.

## Interface
Parameters:
- `N`, 4, operand and sum width (passed to `sumadorb`)
- `R`, 4, number of requesters (≥2)
- `IW`, `$clog2(R)`, requester ID width (derived, not overridden)

Ports:
- `clk_i`  in  1  clock; all logic on rising edge
- `rst_n_i`  in  1  reset, synchronous, active-low
- `req_valid_i`  in  R  per-requester operand valid
- `req_ready_o`  out  R  per-requester accept; one-hot or zero
- `a_i`  in  R*N  packed operand A; requester k at `[k*N +: N]`
- `b_i`  in  R*N  packed operand B; same packing
- `res_valid_o`  out  1  result held in output register
- `res_ready_i`  in  1  consumer accepts result
- `res_sum_o`  out  N  registered sum, `(a+b) mod 2^N`
- `res_id_o`  out  IW  index of requester that produced `res_sum_o`

## Operation
- One clock domain, `clk_i`. Reset is synchronous and active-low on `rst_n_i`.
- States:
  - IDLE: output register empty.
  - FULL: `res_valid_o`=1.
- `accept_en` = (state==IDLE) || (state==FULL && res_ready_i).
- Winner: first k with `req_valid_i[k]`=1, searching from `ptr` upward modulo R.
- `req_ready_o[winner]` = `accept_en`. All other bits are 0.
  - `req_ready_o` is combinational from `req_valid_i`, `ptr`, state and `res_ready_i`.
- On handshake (`accept_en` and any valid):
  - Winner's a/b go through the shared `sumadorb`.
  - Sum is stored to `res_sum_o`, winner to `res_id_o`.
  - `ptr` ← (winner+1) mod R. State → FULL.
- FULL with `res_ready_i`=1 and no valid request: state → IDLE, `res_valid_o` → 0. `res_sum_o`/`res_id_o` keep their last values.
- FULL with `res_ready_i`=0: everything holds. `req_ready_o`=0, `ptr` unchanged.
- Arithmetic: N-bit wrap, carry discarded (15+15 → 14 at N=4).
- `ptr` advances only on a handshake, never on idle cycles.
- Requesters must hold valid and operands stable until ready. The arbiter does not latch requests that are not granted.

## Timing
- Reset values: `res_valid_o`=0, `res_sum_o`=0, `res_id_o`=0, `ptr`=0, state=IDLE, `req_ready_o`=0.
- Reset asserted mid-operation:
  - Takes effect on the next edge and discards any held result.
  - While `rst_n_i`=0, `req_ready_o` is forced to 0.
- Latency: request accepted in cycle t → `res_valid_o`=1 with its sum in cycle t+1.
- Throughput: one result per cycle while `res_ready_i`=1. Back-to-back accept is allowed in the same cycle the previous result drains.
- Fairness: with all R valid continuously and no backpressure, each requester is granted once every R cycles.
- Result channel: `res_sum_o`/`res_id_o` are stable while `res_valid_o`=1 and `res_ready_i`=0.

## Structure
- Shared package `sumador_pkg`:
  - state enum `arb_state_t` {IDLE, FULL}
  - function `rr_pick(valid, ptr)` returning winner index plus found flag
- Sub-module: one `sumadorb #(N)` instance, fed by the muxed winner operands.
- Remaining logic stays in a single module (FSM, ptr, output register).

## Test plan
All scenarios use N=4, R=4.
1. Reset: hold `rst_n_i`=0 for 2 cycles with all valids high → `req_ready_o`=0000, `res_valid_o`=0, sum=0, id=0.
2. Single request: only req1 valid, a=0101, b=0100 → `req_ready_o`=0010 that cycle. Next cycle `res_valid_o`=1, sum=1001, id=1.
3. Overflow: req3 a=1111, b=1111 → sum=1110, id=3.
4. Round-robin: all four valid continuously, `res_ready_i`=1 → ids 0,1,2,3,0,1 on consecutive cycles, one result per cycle.
5. Backpressure:
   - Result pending, `res_ready_i`=0 for 3 cycles → sum/id stable, `req_ready_o`=0000, `ptr` unchanged.
   - Raise `res_ready_i` → next requester accepted the same cycle, new result next cycle.
6. Reset mid-operation: assert `rst_n_i`=0 while `res_valid_o`=1 (id=2) → next cycle `res_valid_o`=0. After release, req0 wins over req1 when both are valid.

Source files
------------

// File: rtl/sumador_pkg.sv
// Shared types and the round-robin pick function for the sumador arbiter.
// rr_pick works on a fixed maximum width; callers zero-extend and pass their real R.
package sumador_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } arb_state_t;

  // Largest requester count rr_pick can handle.
  localparam int RR_MAX_R  = 16;
  localparam int RR_MAX_IW = 4;

  typedef struct packed {
    logic                 found;
    logic [RR_MAX_IW-1:0] idx;
  } rr_pick_t;

  // First valid index at or above ptr, wrapping modulo r.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_R-1:0]  valid,
                                       input logic [RR_MAX_IW-1:0] ptr,
                                       input int                   r);
    rr_pick_t             pick;
    int                   cand;
    logic [RR_MAX_IW-1:0] cidx;
    pick = '0;
    for (int off = 0; off < RR_MAX_R; off++) begin
      cand = int'(ptr) + off;
      if (cand >= r) cand = cand - r;
      cidx = cand[RR_MAX_IW-1:0];
      if (off < r && !pick.found && valid[cidx]) begin
        pick.found = 1'b1;
        pick.idx   = cidx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sumadorb.sv
// Plain N-bit adder; the carry out is dropped so the sum wraps modulo 2^N.
module sumadorb #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_sum
);

  assign o_sum = i_a + i_b;

endmodule

// File: rtl/sumador_rr_arb.sv
// Round-robin arbiter sharing one sumadorb among R requesters, with a single
// registered result channel (valid/ready) tagged by the winning requester ID.
module sumador_rr_arb
  import sumador_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int R  = 4,
  localparam int IW = $clog2(R)
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic [R-1:0]   req_valid_i,
  output logic [R-1:0]   req_ready_o,
  input  logic [R*N-1:0] a_i,
  input  logic [R*N-1:0] b_i,
  output logic           res_valid_o,
  input  logic           res_ready_i,
  output logic [N-1:0]   res_sum_o,
  output logic [IW-1:0]  res_id_o
);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_id;
  logic [N-1:0]  r_sum;

  rr_pick_t      w_pick;
  logic          w_accept_en;
  logic          w_handshake;
  logic [R-1:0]  w_grant;
  logic [IW-1:0] w_ptr_nxt;
  logic [N-1:0]  w_a;
  logic [N-1:0]  w_b;
  logic [N-1:0]  w_sum;

  // R must not exceed RR_MAX_R; the casts below zero-extend into the pick width.
  assign w_pick      = rr_pick(RR_MAX_R'(req_valid_i), RR_MAX_IW'(r_ptr), R);
  assign w_accept_en = (r_state == IDLE) || res_ready_i;
  assign w_handshake = w_accept_en && w_pick.found;
  assign w_grant     = {{(R-1){1'b0}}, 1'b1} << w_pick.idx;
  assign w_ptr_nxt   = (int'(w_pick.idx) + 1 == R) ? '0 : IW'(w_pick.idx + 1'b1);

  assign w_a = a_i[w_pick.idx*N +: N];
  assign w_b = b_i[w_pick.idx*N +: N];

  sumadorb #(.N(N)) u_add (
    .i_a   (w_a),
    .i_b   (w_b),
    .o_sum (w_sum)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: default first, so no path leaves w_state_nxt unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_handshake) w_state_nxt = FULL;
      FULL:    if (res_ready_i && !w_handshake) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    res_valid_o = (r_state == FULL);
    req_ready_o = '0;
    if (rst_n_i && w_handshake) req_ready_o = w_grant;
  end

  // NOTE: the result register is reset too, so a held result is discarded
  // and sum/id read back as zero after reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_ptr <= '0;
      r_sum <= '0;
      r_id  <= '0;
    end else if (w_handshake) begin
      r_ptr <= w_ptr_nxt;
      r_sum <= w_sum;
      r_id  <= IW'(w_pick.idx);
    end
  end

  assign res_sum_o = r_sum;
  assign res_id_o  = r_id;

endmodule

// File: tb/tb_sumador_rr_arb.sv
// Self-checking bench for sumador_rr_arb (N=4, R=4): vector table plus
// hand-written reset sequences, results tracked through a scoreboard queue.
module tb_sumador_rr_arb;

  localparam int N  = 4;
  localparam int R  = 4;
  localparam int IW = 2;

  typedef struct {
    logic [R-1:0]   valid;
    logic [R*N-1:0] a;
    logic [R*N-1:0] b;
    logic           rdy;
    logic [R-1:0]   exp_ready;
    logic           exp_valid;
  } vec_t;

  typedef struct {
    logic [N-1:0]  sum;
    logic [IW-1:0] id;
  } res_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R*N-1:0] a;
  logic [R*N-1:0] b;
  logic           res_valid;
  logic           res_ready;
  logic [N-1:0]   res_sum;
  logic [IW-1:0]  res_id;

  int   checks   = 0;
  int   failures = 0;
  res_t sb[$];
  res_t last;
  vec_t vecs[$];

  always #5 clk = ~clk;

  sumador_rr_arb #(.N(N), .R(R)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .a_i         (a),
    .b_i         (b),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_sum_o   (res_sum),
    .res_id_o    (res_id)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [R-1:0] valid, input logic [R*N-1:0] va,
                              input logic [R*N-1:0] vb, input logic rdy,
                              input logic [R-1:0] exp_ready, input logic exp_valid);
    vec_t v;
    v.valid = valid; v.a = va; v.b = vb; v.rdy = rdy;
    v.exp_ready = exp_ready; v.exp_valid = exp_valid;
    return v;
  endfunction

  // Drive one cycle, check the combinational grant, push the expected result,
  // then after the edge pop it and check the result channel.
  task automatic run_vec(input vec_t v, input string tag);
    res_t e;
    req_valid = v.valid; a = v.a; b = v.b; res_ready = v.rdy;
    #1;
    check({tag, ".req_ready"}, 32'(req_ready), 32'(v.exp_ready));
    if (v.exp_ready != '0) begin
      for (int k = 0; k < R; k++) begin
        if (v.exp_ready[k]) begin
          e.sum = v.a[k*N +: N] + v.b[k*N +: N];
          e.id  = IW'(k);
        end
      end
      sb.push_back(e);
    end
    @(posedge clk); #1;
    if (sb.size() > 0) last = sb.pop_front();
    check({tag, ".res_valid"}, 32'(res_valid), 32'(v.exp_valid));
    check({tag, ".res_sum"},   32'(res_sum),   32'(last.sum));
    check({tag, ".res_id"},    32'(res_id),    32'(last.id));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with every requester asserting valid.
    rst_n = 1'b0; req_valid = '1; a = 16'h1234; b = 16'h4321; res_ready = 1'b0;
    #1;
    check("rst.req_ready_comb", 32'(req_ready), 32'h0);
    repeat (2) begin @(posedge clk); #1; end
    check("rst.req_ready", 32'(req_ready), 32'h0);
    check("rst.res_valid", 32'(res_valid), 32'h0);
    check("rst.res_sum",   32'(res_sum),   32'h0);
    check("rst.res_id",    32'(res_id),    32'h0);
    rst_n = 1'b1;
    last.sum = '0; last.id = '0;

    vecs.push_back(mk(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 1'b0)); // idle, ptr stays 0
    vecs.push_back(mk(4'b0010, 16'h0050, 16'h0040, 1'b1, 4'b0010, 1'b1)); // single req1: 5+4
    vecs.push_back(mk(4'b1000, 16'hF000, 16'hF000, 1'b1, 4'b1000, 1'b1)); // overflow 15+15
    vecs.push_back(mk(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 1'b0)); // drain to IDLE
    vecs.push_back(mk(4'b1111, 16'h9A7C, 16'h36F5, 1'b1, 4'b0001, 1'b1)); // round robin
    vecs.push_back(mk(4'b1111, 16'h9A7C, 16'h36F5, 1'b1, 4'b0010, 1'b1));
    vecs.push_back(mk(4'b1111, 16'h9A7C, 16'h36F5, 1'b1, 4'b0100, 1'b1));
    vecs.push_back(mk(4'b1111, 16'h9A7C, 16'h36F5, 1'b1, 4'b1000, 1'b1));
    vecs.push_back(mk(4'b1111, 16'h1E2B, 16'h8817, 1'b1, 4'b0001, 1'b1));
    vecs.push_back(mk(4'b1111, 16'h1E2B, 16'h8817, 1'b1, 4'b0010, 1'b1));
    vecs.push_back(mk(4'b1111, 16'h1E2B, 16'h8817, 1'b0, 4'b0000, 1'b1)); // backpressure x3
    vecs.push_back(mk(4'b1111, 16'h1E2B, 16'h8817, 1'b0, 4'b0000, 1'b1));
    vecs.push_back(mk(4'b1111, 16'h1E2B, 16'h8817, 1'b0, 4'b0000, 1'b1));
    vecs.push_back(mk(4'b1111, 16'h1E2B, 16'h8817, 1'b1, 4'b0100, 1'b1)); // drain + accept req2
    vecs.push_back(mk(4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b1)); // hold id2

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset while a result (id 2) is pending.
    rst_n = 1'b0; req_valid = 4'b0011; a = 16'h0034; b = 16'h0012; res_ready = 1'b0;
    #1;
    check("midrst.req_ready_comb", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    check("midrst.res_valid", 32'(res_valid), 32'h0);
    check("midrst.res_sum",   32'(res_sum),   32'h0);
    check("midrst.res_id",    32'(res_id),    32'h0);
    sb.delete();
    last.sum = '0; last.id = '0;
    rst_n = 1'b1;

    // req0 beats req1 after reset; then ptr=1 with only req0 valid must wrap.
    run_vec(mk(4'b0011, 16'h0034, 16'h0012, 1'b1, 4'b0001, 1'b1), "post_rst");
    run_vec(mk(4'b0001, 16'h0007, 16'h0009, 1'b1, 4'b0001, 1'b1), "wrap");
    run_vec(mk(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 1'b0), "final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
